// File: rtl/huff_bit_packer_if.sv
// Codeword-in / packed-word-out bus of the Huffman transmit bit packer.
// The master side (symbol encoder plus downstream sink) drives the codewords
// and out_ready. The slave side (the packer) drives everything else.
interface huff_bit_packer_if #(
    parameter int MAX_CODE = 9,
    parameter int OUT_W    = 4
);
    logic                code_valid;
    logic                code_ready;
    logic [MAX_CODE-1:0] code_bits;
    logic [3:0]          code_len;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_bits;
    logic [2:0]          out_len;
    logic [3:0]          bit_count;
    logic                len_err;
    logic                flush_done;

    modport master (
        output code_valid, code_bits, code_len, flush, out_ready,
        input  code_ready, out_valid, out_bits, out_len, bit_count, len_err, flush_done
    );

    modport slave (
        input  code_valid, code_bits, code_len, flush, out_ready,
        output code_ready, out_valid, out_bits, out_len, bit_count, len_err, flush_done
    );
endinterface

// File: rtl/huff_bit_packer.sv
// huff_bit_packer: packs 1..9-bit codewords into a bit-0-first stream and
// emits it as 4-bit words. A flush drains the trailing partial word with its
// real length. All outputs are decoded from registered state only.
module huff_bit_packer #(
    parameter int MAX_CODE = 9,
    parameter int OUT_W    = 4,
    parameter int BUF_W    = MAX_CODE + OUT_W - 1
) (
    input  logic             clk,
    input  logic             reset_n,
    huff_bit_packer_if.slave bus
);
    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    localparam logic [3:0] WORD_LEN  = 4'(OUT_W);
    // A new codeword is accepted only if the longest one still fits.
    localparam logic [3:0] READY_MAX = 4'(BUF_W - MAX_CODE);
    localparam logic [3:0] MAX_LEN   = 4'(MAX_CODE);

    state_e           state_q, state_d;
    logic [BUF_W-1:0] pack_q, pack_d;
    logic [3:0]       count_q, count_d;
    logic             len_err_q, len_err_d;

    logic             code_ready_w;
    logic             out_valid_w;
    logic [2:0]       out_len_w;
    logic [OUT_W-1:0] out_mask;

    logic             pop;
    logic             accept;
    logic             len_ok;
    logic [3:0]       pop_n;
    logic [3:0]       count_post;
    logic [BUF_W-1:0] kept;
    logic [BUF_W-1:0] code_mask;
    logic [BUF_W-1:0] code_ext;

    // Output view of the buffer: word availability, length and mask.
    always_comb begin
        code_ready_w = (state_q == ST_RUN) && (count_q <= READY_MAX);
        out_valid_w  = (state_q == ST_RUN) ? (count_q >= WORD_LEN) : (count_q != 4'd0);
        out_len_w    = (count_q >= WORD_LEN) ? WORD_LEN[2:0] : count_q[2:0];
        out_mask     = (OUT_W'(1) << out_len_w) - OUT_W'(1);
    end

    assign bus.code_ready = code_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_bits   = pack_q[OUT_W-1:0] & out_mask;
    assign bus.out_len    = out_len_w;
    assign bus.bit_count  = count_q;
    assign bus.len_err    = len_err_q;
    assign bus.flush_done = (state_q == ST_FLUSH) && (count_q == 4'd0);

    // Buffer update: pop the head word first, then append at the post-pop fill level.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        pop        = out_valid_w && bus.out_ready;
        pop_n      = pop ? {1'b0, out_len_w} : 4'd0;
        accept     = bus.code_valid && code_ready_w;
        len_ok     = (bus.code_len != 4'd0) && (bus.code_len <= MAX_LEN);
        kept       = pack_q >> pop_n;
        count_post = count_q - pop_n;
        code_mask  = (BUF_W'(1) << bus.code_len) - BUF_W'(1);
        code_ext   = BUF_W'(bus.code_bits) & code_mask;
        pack_d     = kept;
        count_d    = count_post;
        len_err_d  = 1'b0;
        if (accept) begin
            if (len_ok) begin
                pack_d  = kept | (code_ext << count_post);
                count_d = count_post + bus.code_len;
            end else begin
                len_err_d = 1'b1;
            end
        end
    end

    // Mode control: enter FLUSH on request, return once the buffer has drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.flush) state_d = ST_FLUSH;
            ST_FLUSH: if (count_q == 4'd0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            // NOTE: the packing buffer is cleared on reset because appends rely on all bits above count being zero.
            pack_q    <= '0;
            count_q   <= 4'd0;
            len_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            pack_q    <= pack_d;
            count_q   <= count_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: tb/tb_huff_bit_packer.sv
// Self-checking bench for huff_bit_packer: a bit-queue model of the stream is
// compared with the DUT every cycle, and the emitted words of each directed
// scenario are compared with hand-derived literal word lists.
module tb_huff_bit_packer;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    huff_bit_packer_if bus ();

    huff_bit_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Stream model: the bits still waiting, in transmit order.
    bit         mq[$];
    bit         m_flush = 1'b0;
    bit         m_err   = 1'b0;
    // Words the DUT handed over, encoded {out_len, out_bits}.
    logic [6:0] out_log[$];
    logic [6:0] exp_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        int         n;
        logic [2:0] e_len;
        logic [3:0] e_bits;
        logic       e_valid, e_ready, e_done, err_n;
        if (!reset_n) begin
            mq.delete();
            m_flush = 1'b0;
            m_err   = 1'b0;
        end
        n       = mq.size();
        e_len   = (n >= 4) ? 3'd4 : 3'(n);
        e_valid = m_flush ? (n > 0) : (n >= 4);
        e_ready = !m_flush && (n <= 3);
        e_done  = m_flush && (n == 0);
        e_bits  = 4'd0;
        for (int i = 0; i < int'(e_len); i++) e_bits[i] = mq[i];
        check("cyc_code_ready", bus.code_ready, e_ready);
        check("cyc_out_valid",  bus.out_valid,  e_valid);
        check("cyc_out_len",    bus.out_len,    e_len);
        check("cyc_out_bits",   bus.out_bits,   e_bits);
        check("cyc_bit_count",  bus.bit_count,  n);
        check("cyc_len_err",    bus.len_err,    m_err);
        check("cyc_flush_done", bus.flush_done, e_done);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            out_log.push_back({bus.out_len, bus.out_bits});
        if (reset_n) begin
            err_n = 1'b0;
            if (e_valid && bus.out_ready)
                for (int i = 0; i < int'(e_len); i++) void'(mq.pop_front());
            if (bus.code_valid && e_ready) begin
                if (bus.code_len >= 4'd1 && bus.code_len <= 4'd9)
                    for (int i = 0; i < int'(bus.code_len); i++) mq.push_back(bus.code_bits[i]);
                else
                    err_n = 1'b1;
            end
            if (m_flush) begin
                if (n == 0) m_flush = 1'b0;
            end else if (bus.flush) begin
                m_flush = 1'b1;
            end
            m_err = err_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one codeword (optionally with flush) until it is accepted.
    task automatic send(input logic [8:0] bits, input logic [3:0] len, input logic with_flush);
        logic acc;
        int   budget;
        bus.code_valid = 1'b1;
        bus.code_bits  = bits;
        bus.code_len   = len;
        bus.flush      = with_flush;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = bus.code_ready;
            tick();
            budget++;
        end
        bus.code_valid = 1'b0;
        bus.flush      = 1'b0;
        if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            got = bus.flush_done;
        end
        check(name, {31'd0, got}, 32'd1);
        tick();
    endtask

    task automatic check_log(input string name);
        int n;
        check($sformatf("%s_nwords", name), out_log.size(), exp_log.size());
        n = (out_log.size() < exp_log.size()) ? out_log.size() : exp_log.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", name, i), out_log[i], exp_log[i]);
        out_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.code_valid = 1'b0;
        bus.code_bits  = '0;
        bus.code_len   = 4'd0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_code_ready", bus.code_ready, 1);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_len",    bus.out_len,    0);
        check("rst_out_bits",   bus.out_bits,   0);
        check("rst_bit_count",  bus.bit_count,  0);
        check("rst_len_err",    bus.len_err,    0);
        check("rst_flush_done", bus.flush_done, 0);
        reset_n = 1'b1;
        tick();

        // Stream 0 1110 1100 1010 111111.
        send(9'd0,   4'd1, 1'b0);
        send(9'h007, 4'd4, 1'b0);
        send(9'h003, 4'd4, 1'b0);
        send(9'h005, 4'd4, 1'b0);
        send(9'h03F, 4'd6, 1'b0);
        pulse_flush();
        wait_done("stream_done");
        exp_log = '{7'h4E, 7'h46, 7'h4A, 7'h4E, 7'h37};
        check_log("stream");

        // Longest codeword, 9 bits.
        send(9'b010011111, 4'd9, 1'b0);
        pulse_flush();
        wait_done("long_done");
        exp_log = '{7'h4F, 7'h49, 7'h10};
        check_log("long");

        // Backpressure: head word must hold and later codes must wait.
        bus.out_ready = 1'b0;
        send(9'h00A, 4'd4, 1'b0);
        bus.code_valid = 1'b1;
        bus.code_bits  = 9'h005;
        bus.code_len   = 4'd4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_code_ready", bus.code_ready, 0);
            check("bp_out_valid",  bus.out_valid,  1);
            check("bp_out_bits",   bus.out_bits,   4'hA);
            check("bp_bit_count",  bus.bit_count,  4);
        end
        tick();
        bus.out_ready = 1'b1;
        send(9'h005, 4'd4, 1'b0);
        send(9'h00C, 4'd4, 1'b0);
        send(9'h003, 4'd4, 1'b0);
        repeat (3) tick();
        exp_log = '{7'h4A, 7'h45, 7'h4C, 7'h43};
        check_log("bp");

        // Illegal lengths 0 and 10 are consumed and flagged, buffer untouched.
        send(9'h005, 4'd3, 1'b0);
        send(9'h1FF, 4'd0, 1'b0);
        @(negedge clk);
        check("len0_err",   bus.len_err,   1);
        check("len0_count", bus.bit_count, 3);
        tick();
        @(negedge clk);
        check("len0_err_clear", bus.len_err, 0);
        tick();
        send(9'h1FF, 4'd10, 1'b0);
        @(negedge clk);
        check("len10_err",   bus.len_err,   1);
        check("len10_count", bus.bit_count, 3);
        tick();
        pulse_flush();
        wait_done("badlen_done");
        exp_log = '{7'h35};
        check_log("badlen");

        // Flush with an empty buffer.
        pulse_flush();
        @(negedge clk);
        check("fe_done",  bus.flush_done, 1);
        check("fe_valid", bus.out_valid,  0);
        tick();
        @(negedge clk);
        check("fe_done_clear", bus.flush_done, 0);
        check("fe_ready",      bus.code_ready, 1);
        tick();
        exp_log = {};
        check_log("flush_empty");

        // Flush together with a 2-bit code; upper code bits must be ignored.
        send(9'b111111101, 4'd2, 1'b1);
        @(negedge clk);
        check("f2_valid", bus.out_valid, 1);
        check("f2_len",   bus.out_len,   2);
        check("f2_bits",  bus.out_bits,  4'b0001);
        wait_done("f2_done");
        exp_log = '{7'h21};
        check_log("flush2");

        // Reset in the middle of a pending flush discards everything at once.
        bus.out_ready = 1'b0;
        send(9'h007, 4'd3, 1'b0);
        pulse_flush();
        reset_n = 1'b0;
        #1;
        check("mid_rst_count", bus.bit_count,  0);
        check("mid_rst_ready", bus.code_ready, 1);
        check("mid_rst_valid", bus.out_valid,  0);
        check("mid_rst_done",  bus.flush_done, 0);
        tick();
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        exp_log = {};
        check_log("mid_rst");

        // Traffic after reset resumes normally.
        send(9'h003, 4'd2, 1'b0);
        pulse_flush();
        wait_done("post_rst_done");
        exp_log = '{7'h23};
        check_log("post_rst");

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
